// File: rtl/cv32e40p_instr_obi_responder.sv
// cv32e40p_instr_obi_responder
//   Responder (memory) side of the OBI instruction-fetch interface. It grants
//   requests while fewer than MAX_OUTSTANDING responses are pending, reads a
//   synchronous word-wide memory port and returns the responses in order,
//   each at least LATENCY cycles after its grant. The stall_i and resp_hold_i
//   inputs let a testbench suppress grants or responses.
//
//   Optional feature macro: CV32E40P_INSTR_RESP_ERR_EN
//     defined   : a word index beyond MEM_WORDS gives an error response with
//                 zero data and no memory access
//     undefined : addresses wrap modulo MEM_WORDS and instr_err_o is tied 0
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   instr_req_i     OBI request
//   instr_addr_i    byte address (bits [1:0] ignored)
//   instr_gnt_o     OBI grant (combinational)
//   instr_rvalid_o  response valid
//   instr_rdata_o   response data (0 when no response)
//   instr_err_o     response error (0 when no response)
//   stall_i         forces instr_gnt_o low
//   resp_hold_i     holds back instr_rvalid_o
//   mem_req_o       memory read strobe
//   mem_addr_o      memory word index
//   mem_rdata_i     memory data, valid the cycle after mem_req_o

module cv32e40p_instr_obi_responder #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MEM_WORDS       = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          instr_req_i,
    input  logic [31:0]                   instr_addr_i,
    output logic                          instr_gnt_o,
    output logic                          instr_rvalid_o,
    output logic [31:0]                   instr_rdata_o,
    output logic                          instr_err_o,
    input  logic                          stall_i,
    input  logic                          resp_hold_i,
    output logic                          mem_req_o,
    output logic [$clog2(MEM_WORDS)-1:0]  mem_addr_o,
    input  logic [31:0]                   mem_rdata_i
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
    localparam logic [2:0]    FULL_OCC = 3'(MAX_OUTSTANDING);
    localparam logic [3:0]    LAT      = 4'(LATENCY);

    // Response queue storage
    logic [31:0]                q_data [MAX_OUTSTANDING];
    logic [3:0]                 q_age  [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] q_valid;
    logic [MAX_OUTSTANDING-1:0] q_cap;
    logic [MAX_OUTSTANDING-1:0] q_err;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [2:0]    occ;

    // Entry granted last cycle whose memory data is on mem_rdata_i right now
    logic          pend_valid;
    logic [PW-1:0] pend_ptr;

    logic          bypass;
    logic          head_ready;
    logic          retire;
    logic          gnt;
    logic          addr_err;
    logic [31:0]   head_data;
    logic          unused_addr_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign unused_addr_bits = ^{instr_addr_i[1:0], instr_addr_i >> (2 + AW)};

`ifdef CV32E40P_INSTR_RESP_ERR_EN
    assign addr_err = |(instr_addr_i >> (2 + AW));
`else
    assign addr_err = 1'b0;
`endif

    // Head data may still be on the memory bus (LATENCY=1 bypass)
    assign bypass     = pend_valid && (pend_ptr == rd_ptr);
    assign head_ready = q_valid[rd_ptr] && (q_cap[rd_ptr] || bypass) && (q_age[rd_ptr] >= LAT);
    assign retire     = head_ready && !resp_hold_i;
    assign gnt        = instr_req_i && !stall_i && ((occ < FULL_OCC) || retire);

    assign instr_gnt_o = gnt;
    assign mem_req_o   = gnt && !addr_err;
    assign mem_addr_o  = mem_req_o ? instr_addr_i[2 +: AW] : '0;

    always_comb begin
        head_data = q_data[rd_ptr];
        if (bypass) begin
            head_data = q_err[rd_ptr] ? '0 : mem_rdata_i;
        end
    end

    assign instr_rvalid_o = retire;
    assign instr_rdata_o  = retire ? head_data : '0;
`ifdef CV32E40P_INSTR_RESP_ERR_EN
    assign instr_err_o    = retire && q_err[rd_ptr];
`else
    assign instr_err_o    = 1'b0;
`endif

    // Update order matters: capture, then retire, then the new grant, so a
    // grant into the slot freed this same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                q_data[i] <= '0;
                q_age[i]  <= '0;
            end
            q_valid    <= '0;
            q_cap      <= '0;
            q_err      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ        <= '0;
            pend_valid <= 1'b0;
            pend_ptr   <= '0;
        end else begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                if (q_valid[i] && (q_age[i] != 4'hF)) begin
                    q_age[i] <= q_age[i] + 4'd1;
                end
            end

            if (pend_valid) begin
                q_data[pend_ptr] <= q_err[pend_ptr] ? '0 : mem_rdata_i;
                q_cap[pend_ptr]  <= 1'b1;
            end

            if (retire) begin
                q_valid[rd_ptr] <= 1'b0;
                rd_ptr          <= ptr_inc(rd_ptr);
            end

            if (gnt) begin
                q_valid[wr_ptr] <= 1'b1;
                q_age[wr_ptr]   <= 4'd1;
                q_cap[wr_ptr]   <= 1'b0;
                q_err[wr_ptr]   <= addr_err;
                q_data[wr_ptr]  <= '0;
                wr_ptr          <= ptr_inc(wr_ptr);
            end

            pend_valid <= gnt;
            pend_ptr   <= wr_ptr;

            case ({gnt, retire})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_instr_obi_responder.sv
module tb_cv32e40p_instr_obi_responder;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          stall;
        bit          hold;
        bit          eg;
        bit          erv;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // DUT A: LATENCY=1, MAX_OUTSTANDING=2
    logic        req_a = 1'b0, stall_a = 1'b0, hold_a = 1'b0;
    logic [31:0] addr_a = '0;
    logic        gnt_a, rv_a, err_a, mreq_a;
    logic [31:0] rdata_a;
    logic [9:0]  maddr_a;
    logic [31:0] mrdata_a = '0;

    // DUT B: LATENCY=4, MAX_OUTSTANDING=2
    logic        req_b = 1'b0, stall_b = 1'b0, hold_b = 1'b0;
    logic [31:0] addr_b = '0;
    logic        gnt_b, rv_b, err_b, mreq_b;
    logic [31:0] rdata_b;
    logic [9:0]  maddr_b;
    logic [31:0] mrdata_b = '0;

    logic [31:0] mem [1024];

    exp_t qa[$];
    exp_t qb[$];
    vec_t vecs[$];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cv32e40p_instr_obi_responder #(
        .MAX_OUTSTANDING(2),
        .LATENCY(1),
        .MEM_WORDS(1024)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(req_a), .instr_addr_i(addr_a),
        .instr_gnt_o(gnt_a), .instr_rvalid_o(rv_a),
        .instr_rdata_o(rdata_a), .instr_err_o(err_a),
        .stall_i(stall_a), .resp_hold_i(hold_a),
        .mem_req_o(mreq_a), .mem_addr_o(maddr_a), .mem_rdata_i(mrdata_a)
    );

    cv32e40p_instr_obi_responder #(
        .MAX_OUTSTANDING(2),
        .LATENCY(4),
        .MEM_WORDS(1024)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(req_b), .instr_addr_i(addr_b),
        .instr_gnt_o(gnt_b), .instr_rvalid_o(rv_b),
        .instr_rdata_o(rdata_b), .instr_err_o(err_b),
        .stall_i(stall_b), .resp_hold_i(hold_b),
        .mem_req_o(mreq_b), .mem_addr_o(maddr_b), .mem_rdata_i(mrdata_b)
    );

    // Synchronous memory: data valid the cycle after the strobe
    always @(posedge clk) begin
        if (mreq_a) mrdata_a <= mem[maddr_a];
        if (mreq_b) mrdata_b <= mem[maddr_b];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    function automatic exp_t model(input logic [31:0] addr);
        exp_t e;
        logic [31:0] upper;
        upper = addr >> 12;
`ifdef CV32E40P_INSTR_RESP_ERR_EN
        e.err = (upper != 0);
`else
        e.err = 1'b0;
`endif
        e.data = e.err ? 32'h0 : mem[addr[11:2]];
        return e;
    endfunction

    // Scoreboard: push on grant, pop and compare on rvalid
    task automatic sample(input int which, input logic [31:0] addr);
        logic g, mq, rv, er;
        logic [9:0] ma;
        logic [31:0] rd;
        exp_t e, p;
        bit empty;
        if (which == 0) begin
            g = gnt_a; mq = mreq_a; ma = maddr_a; rv = rv_a; rd = rdata_a; er = err_a;
        end else begin
            g = gnt_b; mq = mreq_b; ma = maddr_b; rv = rv_b; rd = rdata_b; er = err_b;
        end
        if (g) begin
            e = model(addr);
            check("mem_req_on_gnt", 32'(mq), 32'(!e.err));
            if (!e.err) check("mem_addr", 32'(ma), 32'(addr[11:2]));
            if (which == 0) qa.push_back(e); else qb.push_back(e);
        end else begin
            check("mem_req_idle", 32'(mq), 32'h0);
        end
        if (rv) begin
            empty = (which == 0) ? (qa.size() == 0) : (qb.size() == 0);
            if (empty) begin
                check("rvalid_with_empty_sb", 32'(rv), 32'h0);
            end else begin
                p = (which == 0) ? qa.pop_front() : qb.pop_front();
                check("rdata", rd, p.data);
                check("err", 32'(er), 32'(p.err));
            end
        end else begin
            check("rdata_idle_zero", rd, 32'h0);
            check("err_idle_zero", 32'(er), 32'h0);
        end
    endtask

    task automatic cycle_a(input bit req, input logic [31:0] addr, input bit stall,
                           input bit hold, output bit g, output bit rv);
        @(negedge clk);
        req_a = req; addr_a = addr; stall_a = stall; hold_a = hold;
        #4;
        g = gnt_a;
        rv = rv_a;
        sample(0, addr);
    endtask

    function automatic vec_t mk(bit req, logic [31:0] addr, bit stall, bit hold, bit eg, bit erv);
        vec_t v;
        v.req = req; v.addr = addr; v.stall = stall; v.hold = hold; v.eg = eg; v.erv = erv;
        return v;
    endfunction

    initial begin
        bit g, rv;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
        mem[16] = 32'hDEADBEEF;

        // req, addr, stall, hold, exp gnt, exp rvalid
        vecs.push_back(mk(1, 32'h40, 0, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0,  0, 0, 0, 1));
        vecs.push_back(mk(1, 32'h80, 0, 0, 1, 0));
        vecs.push_back(mk(1, 32'h84, 0, 0, 1, 1));
        vecs.push_back(mk(1, 32'h88, 0, 0, 1, 1));
        vecs.push_back(mk(1, 32'h8C, 0, 0, 1, 1));
        vecs.push_back(mk(0, 32'h0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h90, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'h90, 0, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0,  0, 0, 0, 1));
        vecs.push_back(mk(1, 32'h94, 0, 1, 1, 0));
        vecs.push_back(mk(1, 32'h98, 0, 1, 1, 0));
        vecs.push_back(mk(1, 32'h9C, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h9C, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h9C, 0, 0, 1, 1));
        vecs.push_back(mk(0, 32'h0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 0, 0, 0));

        // Reset values
        #2;
        check("rst_gnt", 32'(gnt_a), 32'h0);
        check("rst_rvalid", 32'(rv_a), 32'h0);
        check("rst_rdata", rdata_a, 32'h0);
        check("rst_err", 32'(err_a), 32'h0);
        check("rst_mem_req", 32'(mreq_a), 32'h0);
        check("rst_mem_addr", 32'(maddr_a), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sequence on the LATENCY=1 responder
        foreach (vecs[i]) begin
            cycle_a(vecs[i].req, vecs[i].addr, vecs[i].stall, vecs[i].hold, g, rv);
            check($sformatf("vec%0d_gnt", i), 32'(g), 32'(vecs[i].eg));
            check($sformatf("vec%0d_rvalid", i), 32'(rv), 32'(vecs[i].erv));
        end
        check("sb_a_drained", 32'(qa.size()), 32'h0);

        // LATENCY=4, two outstanding: gnt 1,1,0,0 repeating, rvalid from cycle 4
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            req_b = (c < 10);
            addr_b = 32'h200 + 32'(c) * 4;
            #4;
            check($sformatf("b%0d_gnt", c), 32'(gnt_b), 32'((c < 10) && (c % 4 < 2)));
            check($sformatf("b%0d_rvalid", c), 32'(rv_b), 32'((c >= 4) && (c < 14) && (c % 4 < 2)));
            sample(1, addr_b);
        end
        check("sb_b_drained", 32'(qb.size()), 32'h0);

        // Reset with two transactions in flight
        cycle_a(1, 32'h100, 0, 1, g, rv);
        check("pre_rst_gnt0", 32'(g), 32'h1);
        cycle_a(1, 32'h104, 0, 1, g, rv);
        check("pre_rst_gnt1", 32'(g), 32'h1);
        @(negedge clk);
        req_a = 1'b0; hold_a = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rvalid", 32'(rv_a), 32'h0);
        check("midrst_rdata", rdata_a, 32'h0);
        check("midrst_mem_req", 32'(mreq_a), 32'h0);
        qa.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle_a(0, 32'h0, 0, 0, g, rv);
        check("post_rst_no_rvalid", 32'(rv), 32'h0);
        cycle_a(1, 32'h40, 0, 1, g, rv);
        check("post_rst_gnt0", 32'(g), 32'h1);
        check("post_rst_rv0", 32'(rv), 32'h0);
        cycle_a(1, 32'h44, 0, 1, g, rv);
        check("post_rst_gnt1", 32'(g), 32'h1);
        check("post_rst_rv1", 32'(rv), 32'h0);
        cycle_a(1, 32'h48, 0, 1, g, rv);
        check("post_rst_full", 32'(g), 32'h0);
        cycle_a(0, 32'h0, 0, 0, g, rv);
        check("post_rst_rv2", 32'(rv), 32'h1);
        cycle_a(0, 32'h0, 0, 0, g, rv);
        check("post_rst_rv3", 32'(rv), 32'h1);
        cycle_a(0, 32'h0, 0, 0, g, rv);
        check("post_rst_rv4", 32'(rv), 32'h0);
        check("sb_a_final", 32'(qa.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
